// File: rtl/seq_divider64_32.sv
// Multi-cycle unsigned restoring divider: DIVIDEND_W-bit dividend / DIVISOR_W-bit divisor,
// one shift/compare/subtract step per clock, start/busy/done handshake.
module seq_divider64_32 #(
  parameter int DIVIDEND_W = 64,
  parameter int DIVISOR_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);
  localparam int CNT_W = $clog2(DIVIDEND_W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                state_q, state_d;
  logic [DIVISOR_W:0]    r_q, r_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    t, diff;
  logic                  ge;
  // R stays below the divisor, so its top bit is always zero and never feeds T.
  logic                  unused_r_msb;
  assign unused_r_msb = r_q[DIVISOR_W];

  always_comb begin
    t       = {r_q[DIVISOR_W-1:0], q_q[DIVIDEND_W-1]};
    diff    = t - {1'b0, dvsr_q};
    ge      = (t >= {1'b0, dvsr_q});
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvsr_d  = dvsr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      // DONE also accepts a request so back-to-back divisions issue every DIVIDEND_W+1 cycles.
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend[DIVISOR_W-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            dvsr_d  = divisor;
            r_d     = '0;
            q_d     = dividend;
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = ge ? diff : t;
        q_d   = {q_q[DIVIDEND_W-2:0], ge};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
          quo_d   = q_d;
          rem_d   = r_d[DIVISOR_W-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvsr_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvsr_q  <= dvsr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider64_32.sv
// Randomized bench for seq_divider64_32: a cycle-count/arithmetic model predicts busy, done
// and results every cycle; directed cases pin the model with hand-computed values.
module tb_seq_divider64_32;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [63:0] quotient;
  logic [31:0] remainder;

  seq_divider64_32 #(.DIVIDEND_W(64), .DIVISOR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a request at an edge when not busy starts a 64-cycle countdown; results are
  // plain / and % and appear with the done cycle. Divide by zero finishes immediately.
  int          m_cnt;
  bit          m_done, m_dbz;
  logic [63:0] m_quo, m_pq;
  logic [31:0] m_rem, m_pr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_done <= 0; m_dbz <= 0;
      m_quo <= '0; m_rem <= '0; m_pq <= '0; m_pr <= '0;
    end else if (m_cnt != 0) begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) begin
        m_quo <= m_pq; m_rem <= m_pr; m_dbz <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        if (divisor == 0) begin
          m_quo <= '1; m_rem <= dividend[31:0]; m_dbz <= 1'b1; m_done <= 1'b1;
        end else begin
          m_cnt <= 64;
          m_pq  <= dividend / {32'b0, divisor};
          m_pr  <= 32'(dividend % {32'b0, divisor});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 64'(busy), 64'(m_cnt != 0));
      chk("done", 64'(done), 64'(m_done));
      chk("quotient", quotient, m_quo);
      chk("remainder", 64'(remainder), 64'(m_rem));
      chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
    end
  end

  // Called just after a negedge; returns at the negedge inside the done cycle.
  task automatic do_div(input string name, input logic [63:0] dd, input logic [31:0] dv,
                        input logic [63:0] eq, input logic [31:0] er, input bit edbz);
    int lat;
    bit seen;
    start = 1'b1; dividend = dd; divisor = dv;
    @(negedge clk);
    start = 1'b0; dividend = {$urandom, $urandom}; divisor = $urandom;
    lat = 1; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
      lat++;
    end
    if (!seen) begin
      n_chk++; n_err++;
      $display("FAIL %s timeout: no done within 100 cycles", name);
    end else begin
      chk({name, " latency"}, 64'(lat), (dv == 0) ? 64'd1 : 64'd65);
      chk({name, " quotient"}, quotient, eq);
      chk({name, " remainder"}, 64'(remainder), 64'(er));
      chk({name, " dbz"}, 64'(div_by_zero), 64'(edbz));
    end
  endtask

  initial begin
    logic [63:0] dd, gap;
    logic [31:0] dv;
    int g;
    bit seen;
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset quotient", quotient, 64'd0);
    chk("reset remainder", 64'(remainder), 64'd0);
    chk("reset dbz", 64'(div_by_zero), 64'd0);
    #21 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    do_div("basic", 64'd100, 32'd7, 64'd14, 32'd2, 1'b0);
    do_div("max/1", 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 1'b0);
    do_div("max/max", 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 64'h1_0000_0001, 32'd0, 1'b0);
    @(negedge clk);
    do_div("small", 64'd5, 32'h8000_0000, 64'd0, 32'd5, 1'b0);
    do_div("zero dividend", 64'd0, 32'd3, 64'd0, 32'd0, 1'b0);
    @(negedge clk);
    do_div("div0", 64'h1234_5678_9ABC_DEF0, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'h9ABC_DEF0, 1'b1);
    @(negedge clk);
    @(negedge clk);

    // start held high through the whole run with new operands
    start = 1'b1; dividend = 64'd100; divisor = 32'd7;
    @(negedge clk);
    dividend = 64'd1000; divisor = 32'd10;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    chk("held first done seen", 64'(seen), 64'd1);
    chk("held first quotient", quotient, 64'd14);
    chk("held first remainder", 64'(remainder), 64'd2);
    @(negedge clk);
    start = 1'b0;
    g = 1; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
      g++;
    end
    chk("held second done seen", 64'(seen), 64'd1);
    chk("held second spacing", 64'(g), 64'd65);
    chk("held second quotient", quotient, 64'd100);
    chk("held second remainder", 64'(remainder), 64'd0);
    @(negedge clk);

    // reset in the middle of a run
    start = 1'b1; dividend = 64'd100; divisor = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst quotient", quotient, 64'd0);
    chk("midrst remainder", 64'(remainder), 64'd0);
    chk("midrst dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("midrst no done", 64'(seen), 64'd0);
    do_div("after reset", 64'd100, 32'd7, 64'd14, 32'd2, 1'b0);

    for (int n = 0; n < 25; n++) begin
      dd = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: dv = 32'd0;
        1: dv = 32'd1;
        2: dv = 32'($urandom_range(2, 15));
        3: begin dv = $urandom; dd = 64'($urandom); end
        default: dv = $urandom;
      endcase
      if (dv == 0) do_div("rand", dd, dv, '1, dd[31:0], 1'b1);
      else do_div("rand", dd, dv, dd / {32'b0, dv}, 32'(dd % {32'b0, dv}), 1'b0);
      gap = 64'($urandom_range(0, 2));
      for (int k = 0; k < int'(gap); k++) @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
